eth_tx_arb: RTL and testbench

Frame-granular round-robin arbiter that shares the single TX byte stream of the Ethernet MAC loopback between NUM_SRC requesters. A grant is held for a whole frame, from first byte to src_last, so frames are never interleaved. Frames longer than MAX_FRAME are truncated: a forced m_last is sent and the rest of the source frame is drained. The block sits directly upstream of the MAC tx_valid/tx_ready/tx_data/tx_last inputs.

---
 rtl/eth_tx_arb_if.sv | 24 ++
 rtl/eth_tx_arb.sv | 158 +++++++++++++++
 tb/tb_eth_tx_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_if.sv
// Byte-stream bundle between the NUM_SRC TX requesters, the arbiter and the MAC TX input.
// The arbiter takes the master side because it drives the m_* stream towards the MAC.
interface eth_tx_arb_if #(
    parameter int NUM_SRC = 4
) ();
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_ready;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [7:0]           m_data;
    logic                 m_last;

    modport master (
        input  src_valid, src_data, src_last, m_ready,
        output src_ready, m_valid, m_data, m_last
    );

    modport slave (
        output src_valid, src_data, src_last, m_ready,
        input  src_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter feeding the MAC TX stream from NUM_SRC requesters.
// Over-length frames get a forced m_last at MAX_FRAME bytes; the source tail is then drained.
module eth_tx_arb #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_FRAME = 512,
    parameter int CNT_W     = 16
) (
    input  logic                       ETH_CLK,
    input  logic                       ETH_RSTn,
    eth_tx_arb_if.master               bus,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           trunc_cnt
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_FRAME + 1);
    localparam logic [GW-1:0] LAST_SRC  = GW'(NUM_SRC - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(MAX_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    state_t            state_r, state_s;
    logic [GW-1:0]     grant_id_r, grant_id_s;
    logic [GW-1:0]     last_grant_r, last_grant_s;
    logic [BW-1:0]     byte_cnt_r, byte_cnt_s;
    logic [CNT_W-1:0]  frame_cnt_r, frame_cnt_s;
    logic [CNT_W-1:0]  trunc_cnt_r, trunc_cnt_s;

    logic [GW-1:0]      cand_s;
    logic [GW-1:0]      win_s;
    logic               found_s;
    logic               valid_g_s;
    logic               last_g_s;
    logic [7:0]         data_g_s;
    logic               hs_s;
    logic               at_max_s;
    logic [NUM_SRC-1:0] grant_mask_s;

    assign valid_g_s    = bus.src_valid[grant_id_r];
    assign last_g_s     = bus.src_last[grant_id_r];
    assign data_g_s     = bus.src_data[{grant_id_r, 3'b000} +: 8];
    assign hs_s         = (state_r == PASS) && valid_g_s && bus.m_ready;
    assign at_max_s     = (byte_cnt_r == LAST_BYTE);
    assign grant_mask_s = NUM_SRC'(1) << grant_id_r;

    assign grant_id  = grant_id_r;
    assign busy      = (state_r != IDLE);
    assign frame_cnt = frame_cnt_r;
    assign trunc_cnt = trunc_cnt_r;

    // Round-robin search: first requester strictly after last_grant, wrapping at NUM_SRC.
    always_comb begin
        found_s = 1'b0;
        win_s   = {GW{1'b0}};
        cand_s  = last_grant_r;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = (cand_s == LAST_SRC) ? {GW{1'b0}} : cand_s + GW'(1);
            if (!found_s && bus.src_valid[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, counter updates and the combinational byte path to the MAC.
    always_comb begin
        state_s       = state_r;
        grant_id_s    = grant_id_r;
        last_grant_s  = last_grant_r;
        byte_cnt_s    = byte_cnt_r;
        frame_cnt_s   = frame_cnt_r;
        trunc_cnt_s   = trunc_cnt_r;
        bus.src_ready = {NUM_SRC{1'b0}};
        bus.m_valid   = 1'b0;
        bus.m_data    = 8'h00;
        bus.m_last    = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_id_s   = win_s;
                    last_grant_s = win_s;
                    byte_cnt_s   = {BW{1'b0}};
                    state_s      = PASS;
                end else begin
                    state_s = IDLE;
                end
            end
            PASS: begin
                bus.m_valid   = valid_g_s;
                bus.m_data    = data_g_s;
                bus.m_last    = last_g_s | at_max_s;
                bus.src_ready = bus.m_ready ? grant_mask_s : {NUM_SRC{1'b0}};
                if (hs_s) begin
                    byte_cnt_s = byte_cnt_r + BW'(1);
                    // A genuine last byte wins over truncation at the limit.
                    if (last_g_s) begin
                        frame_cnt_s = sat_inc(frame_cnt_r);
                        state_s     = IDLE;
                    end else if (at_max_s) begin
                        frame_cnt_s = sat_inc(frame_cnt_r);
                        trunc_cnt_s = sat_inc(trunc_cnt_r);
                        state_s     = DROP;
                    end else begin
                        state_s = PASS;
                    end
                end else begin
                    state_s = PASS;
                end
            end
            DROP: begin
                bus.src_ready = grant_mask_s;
                if (valid_g_s && last_g_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge ETH_CLK or negedge ETH_RSTn) begin
        if (!ETH_RSTn) begin
            state_r      <= IDLE;
            grant_id_r   <= {GW{1'b0}};
            last_grant_r <= LAST_SRC;
            byte_cnt_r   <= {BW{1'b0}};
            frame_cnt_r  <= {CNT_W{1'b0}};
            trunc_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            grant_id_r   <= grant_id_s;
            last_grant_r <= last_grant_s;
            byte_cnt_r   <= byte_cnt_s;
            frame_cnt_r  <= frame_cnt_s;
            trunc_cnt_r  <= trunc_cnt_s;
        end
    end
endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: per-source frame generators, an m_* beat monitor and
// hand-computed expectations for arbitration order, truncation, backpressure and reset.
module tb_eth_tx_arb;
    localparam int NS = 4;
    localparam int MF = 512;
    localparam int CW = 16;

    logic          ETH_CLK  = 1'b0;
    logic          ETH_RSTn = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] trunc_cnt;

    eth_tx_arb_if #(.NUM_SRC(NS)) bus ();

    eth_tx_arb #(.NUM_SRC(NS), .MAX_FRAME(MF), .CNT_W(CW)) dut (
        .ETH_CLK   (ETH_CLK),
        .ETH_RSTn  (ETH_RSTn),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .trunc_cnt (trunc_cnt)
    );

    always #5 ETH_CLK = ~ETH_CLK;

    int n_checks = 0;
    int n_errors = 0;

    int          len_a  [NS];
    int          idx_a  [NS];
    int          left_a [NS];
    logic [7:0]  off_a  [NS];
    logic [NS-1:0] acc;

    logic [7:0]  bd_q[$];
    logic        bl_q[$];
    int          bg_q[$];
    logic        busy_q[$];
    int          drop_n;
    logic        toggle_rdy = 1'b0;
    logic        chk_mirror = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int s = 0; s < NS; s++) begin
            bus.src_valid[s]        = (left_a[s] > 0);
            bus.src_data[8*s +: 8]  = off_a[s] + 8'(idx_a[s]);
            bus.src_last[s]         = (left_a[s] > 0) && (idx_a[s] == len_a[s] - 1);
        end
    endtask

    task automatic start_src(input int s, input int len, input int frames, input logic [7:0] off);
        len_a[s]  = len;
        idx_a[s]  = 0;
        left_a[s] = frames;
        off_a[s]  = off;
    endtask

    function automatic bit any_left();
        bit r = 1'b0;
        for (int s = 0; s < NS; s++) if (left_a[s] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic clear_mon();
        bd_q.delete();
        bl_q.delete();
        bg_q.delete();
        busy_q.delete();
        drop_n = 0;
    endtask

    // One clock: sample at negedge, then advance sources whose byte was accepted.
    task automatic cycle();
        @(negedge ETH_CLK);
        for (int s = 0; s < NS; s++) acc[s] = bus.src_valid[s] && bus.src_ready[s];
        if (bus.m_valid && bus.m_ready) begin
            bd_q.push_back(bus.m_data);
            bl_q.push_back(bus.m_last);
            bg_q.push_back(int'(grant_id));
        end
        if (busy && !bus.m_valid && ((bus.src_ready & bus.src_valid) != 4'b0000)) drop_n++;
        if (chk_mirror && busy)
            check("bp_ready_mirror", 32'(bus.src_ready), bus.m_ready ? 32'h1 : 32'h0);
        busy_q.push_back(busy);
        @(posedge ETH_CLK);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (acc[s]) begin
                if (idx_a[s] == len_a[s] - 1) begin
                    idx_a[s] = 0;
                    left_a[s]--;
                end else begin
                    idx_a[s]++;
                end
            end
        end
        if (toggle_rdy) bus.m_ready = ~bus.m_ready;
        drive_src();
    endtask

    task automatic run_until_done(input int max_cyc, input string tag);
        int n = 0;
        while ((any_left() || busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        if (n >= max_cyc) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_order [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
        int derr, lerr, gerr, run, gaps, bad;
        bit seen;

        for (int s = 0; s < NS; s++) start_src(s, 1, 0, 8'h00);
        bus.m_ready = 1'b1;
        drive_src();

        // Reset values
        repeat (2) @(posedge ETH_CLK);
        #1;
        check("rst_m_valid",   32'(bus.m_valid),   32'h0);
        check("rst_m_last",    32'(bus.m_last),    32'h0);
        check("rst_m_data",    32'(bus.m_data),    32'h0);
        check("rst_src_ready", 32'(bus.src_ready), 32'h0);
        check("rst_busy",      32'(busy),          32'h0);
        check("rst_grant",     32'(grant_id),      32'h0);
        check("rst_frame_cnt", 32'(frame_cnt),     32'h0);
        check("rst_trunc_cnt", 32'(trunc_cnt),     32'h0);
        @(negedge ETH_CLK);
        ETH_RSTn = 1'b1;
        @(posedge ETH_CLK);
        #1;

        // Single source: src1, 10 bytes 0x00..0x09
        clear_mon();
        start_src(1, 10, 1, 8'h00);
        drive_src();
        cycle();
        check("single_grant", 32'(grant_id), 32'd1);
        check("single_busy",  32'(busy),     32'd1);
        run_until_done(40, "single");
        check("single_beats", 32'(bd_q.size()), 32'd10);
        if (bd_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check("single_data", 32'(bd_q[i]), 32'(i));
                check("single_last", 32'(bl_q[i]), (i == 9) ? 32'd1 : 32'd0);
            end
        end
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);
        check("single_idle",      32'(busy),      32'd0);

        // Round robin: all four request two 4-byte frames; last_grant is 1, so order starts at 2
        clear_mon();
        for (int s = 0; s < NS; s++) start_src(s, 4, 2, 8'(s * 64));
        drive_src();
        run_until_done(100, "rr");
        check("rr_beats", 32'(bd_q.size()), 32'd32);
        if (bd_q.size() == 32) begin
            derr = 0; lerr = 0; gerr = 0;
            for (int f = 0; f < 8; f++) begin
                for (int k = 0; k < 4; k++) begin
                    if (bd_q[4*f+k] != 8'(rr_order[f] * 64 + k)) derr++;
                    if (bl_q[4*f+k] != (k == 3)) lerr++;
                    if (bg_q[4*f+k] != rr_order[f]) gerr++;
                end
            end
            check("rr_data_errs",  32'(derr), 32'd0);
            check("rr_last_errs",  32'(lerr), 32'd0);
            check("rr_grant_errs", 32'(gerr), 32'd0);
        end
        run = 0; gaps = 0; bad = 0; seen = 1'b0;
        foreach (busy_q[i]) begin
            if (busy_q[i]) begin
                if (seen && run > 0) begin
                    gaps++;
                    if (run != 1) bad++;
                end
                seen = 1'b1;
                run  = 0;
            end else if (seen) begin
                run++;
            end
        end
        check("rr_gaps",       32'(gaps), 32'd7);
        check("rr_gap_len",    32'(bad),  32'd0);
        check("rr_frame_cnt",  32'(frame_cnt), 32'd9);

        // Truncation: src2 sends 520 bytes
        clear_mon();
        start_src(2, 520, 1, 8'h00);
        drive_src();
        run_until_done(700, "trunc");
        check("trunc_beats", 32'(bd_q.size()), 32'd512);
        if (bd_q.size() == 512) begin
            derr = 0; lerr = 0;
            for (int i = 0; i < 512; i++) begin
                if (bd_q[i] != 8'(i)) derr++;
                if (bl_q[i] != (i == 511)) lerr++;
            end
            check("trunc_data_errs", 32'(derr), 32'd0);
            check("trunc_last_errs", 32'(lerr), 32'd0);
            check("trunc_final_last", 32'(bl_q[511]), 32'd1);
        end
        check("trunc_drops",     32'(drop_n),    32'd8);
        check("trunc_trunc_cnt", 32'(trunc_cnt), 32'd1);
        check("trunc_frame_cnt", 32'(frame_cnt), 32'd10);

        // Exactly MAX_FRAME bytes with a real last: no truncation, no drain
        clear_mon();
        start_src(3, 512, 1, 8'h00);
        drive_src();
        run_until_done(700, "exact");
        check("exact_beats", 32'(bd_q.size()), 32'd512);
        if (bd_q.size() == 512) begin
            lerr = 0;
            for (int i = 0; i < 512; i++) if (bl_q[i] != (i == 511)) lerr++;
            check("exact_last_errs", 32'(lerr), 32'd0);
        end
        check("exact_drops",     32'(drop_n),    32'd0);
        check("exact_trunc_cnt", 32'(trunc_cnt), 32'd1);
        check("exact_frame_cnt", 32'(frame_cnt), 32'd11);

        // Backpressure: m_ready toggles every cycle during a 6-byte frame from src0
        clear_mon();
        start_src(0, 6, 1, 8'hA0);
        drive_src();
        toggle_rdy = 1'b1;
        chk_mirror = 1'b1;
        run_until_done(40, "bp");
        toggle_rdy = 1'b0;
        chk_mirror = 1'b0;
        bus.m_ready = 1'b1;
        check("bp_beats", 32'(bd_q.size()), 32'd6);
        if (bd_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("bp_data", 32'(bd_q[i]), 32'(8'hA0 + 8'(i)));
                check("bp_last", 32'(bl_q[i]), (i == 5) ? 32'd1 : 32'd0);
            end
        end
        check("bp_frame_cnt", 32'(frame_cnt), 32'd12);

        // Reset mid-frame after 3 of 8 bytes
        clear_mon();
        start_src(1, 8, 1, 8'h10);
        drive_src();
        for (int n = 0; n < 30 && bd_q.size() < 3; n++) cycle();
        check("mid_beats_before_rst", 32'(bd_q.size()), 32'd3);
        #2;
        ETH_RSTn = 1'b0;
        #1;
        check("mid_m_valid",   32'(bus.m_valid),   32'h0);
        check("mid_m_last",    32'(bus.m_last),    32'h0);
        check("mid_m_data",    32'(bus.m_data),    32'h0);
        check("mid_src_ready", 32'(bus.src_ready), 32'h0);
        check("mid_busy",      32'(busy),          32'h0);
        check("mid_grant",     32'(grant_id),      32'h0);
        check("mid_frame_cnt", 32'(frame_cnt),     32'h0);
        check("mid_trunc_cnt", 32'(trunc_cnt),     32'h0);
        for (int s = 0; s < NS; s++) start_src(s, 1, 0, 8'h00);
        drive_src();
        @(negedge ETH_CLK);
        ETH_RSTn = 1'b1;
        @(posedge ETH_CLK);
        #1;
        clear_mon();
        start_src(0, 3, 1, 8'h50);
        start_src(2, 3, 1, 8'h60);
        drive_src();
        cycle();
        check("post_rst_grant", 32'(grant_id), 32'd0);
        run_until_done(40, "post_rst");
        check("post_rst_beats", 32'(bd_q.size()), 32'd6);
        if (bd_q.size() == 6) begin
            check("post_rst_first", 32'(bd_q[0]), 32'h50);
            check("post_rst_second_src", 32'(bd_q[3]), 32'h60);
        end
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd2);
        check("post_rst_trunc_cnt", 32'(trunc_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
